// File: rtl/stepdown_prio_sched.sv
// stepdown_prio_sched
// Two-requester grant scheduler driving a priority cell. A request seen in
// IDLE arms the cell for one cycle (the skew codes are latched then). The
// winner is granted in GRANT until a release arrives after the minimum hold
// time has run out. One DRAIN cycle then returns the block to IDLE.
//
// Optional feature: define STEPDOWN_PRIO_ROTATE_EN to break ties round-robin.
// The last-winner register exists only in that build. Without the macro,
// req0 always wins a tie.
//
// Ports
//   clk                    rising-edge clock
//   rb                     asynchronous active-low reset
//   CELV, CELG, CELSUB     supply/ground/substrate pass-through (no logic)
//   req0, req1             level requests (requester 0 / requester X)
//   rel                    level release from the current owner
//   tstate_en              scheduler enable
//   prio0_cfg, priox_cfg   skew codes, latched on IDLE->ARM
//   hold_min               minimum GRANT cycles before rel is honoured
//   gnt0, gnt1             one-hot registered grants
//   busy                   registered (state != IDLE)
//   Tstate                 registered, high in ARM and GRANT
//   Tpriority0, TpriorityX registered skew codes
module stepdown_prio_sched #(
    parameter int unsigned SKEW_W = 2,
    parameter int unsigned HOLD_W = 4
) (
    input  logic              clk,
    input  logic              rb,
    input  logic              CELV,
    input  logic              CELG,
    input  logic              CELSUB,
    input  logic              req0,
    input  logic              req1,
    input  logic              rel,
    input  logic              tstate_en,
    input  logic [SKEW_W-1:0] prio0_cfg,
    input  logic [SKEW_W-1:0] priox_cfg,
    input  logic [HOLD_W-1:0] hold_min,
    output logic              gnt0,
    output logic              gnt1,
    output logic              busy,
    output logic              Tstate,
    output logic [SKEW_W-1:0] Tpriority0,
    output logic [SKEW_W-1:0] TpriorityX
);

    typedef enum logic [1:0] {IDLE, ARM, GRANT, DRAIN} state_e;

    localparam logic [HOLD_W-1:0] HOLD_ONE = {{(HOLD_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              busy_q, busy_d;
    logic              tstate_q, tstate_d;
    logic [SKEW_W-1:0] tp0_q, tp0_d;
    logic [SKEW_W-1:0] tpx_q, tpx_d;
    logic              pick0;

    // Power pins carry no logic; fold them into a sink net.
    logic unused_pwr;
    assign unused_pwr = CELV ^ CELG ^ CELSUB;

`ifdef STEPDOWN_PRIO_ROTATE_EN
    // last_x_q=1: requester X won the previous grant.
    logic last_x_q, last_x_d;
    assign pick0 = req0 & (~req1 | last_x_q);
`else
    assign pick0 = req0;
`endif

    // State and output registers
    always_ff @(posedge clk or negedge rb) begin
        if (!rb) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            busy_q   <= 1'b0;
            tstate_q <= 1'b0;
            tp0_q    <= '0;
            tpx_q    <= '0;
`ifdef STEPDOWN_PRIO_ROTATE_EN
            last_x_q <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            busy_q   <= busy_d;
            tstate_q <= tstate_d;
            tp0_q    <= tp0_d;
            tpx_q    <= tpx_d;
`ifdef STEPDOWN_PRIO_ROTATE_EN
            last_x_q <= last_x_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tstate_en && (req0 || req1)) state_d = ARM;
            ARM: begin
                if (!tstate_en)          state_d = DRAIN;
                else if (req0 || req1)   state_d = GRANT;
                else                     state_d = IDLE;
            end
            GRANT:   if (!tstate_en || (rel && hold_q == '0)) state_d = DRAIN;
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so that they land in
    // registers together with it.
    always_comb begin
        hold_d = hold_q;
        gnt0_d = 1'b0;
        gnt1_d = 1'b0;
        tp0_d  = tp0_q;
        tpx_d  = tpx_q;
`ifdef STEPDOWN_PRIO_ROTATE_EN
        last_x_d = last_x_q;
`endif
        if (state_q == IDLE && state_d == ARM) begin
            tp0_d = prio0_cfg;
            tpx_d = priox_cfg;
        end
        if (state_q == ARM && state_d == GRANT) begin
            gnt0_d = pick0;
            gnt1_d = ~pick0;
            hold_d = hold_min;
`ifdef STEPDOWN_PRIO_ROTATE_EN
            last_x_d = ~pick0;
`endif
        end else if (state_q == GRANT && state_d == GRANT) begin
            gnt0_d = gnt0_q;
            gnt1_d = gnt1_q;
            if (hold_q != '0) hold_d = hold_q - HOLD_ONE;
        end
        busy_d   = (state_d != IDLE);
        tstate_d = (state_d == ARM) || (state_d == GRANT);
    end

    assign gnt0       = gnt0_q;
    assign gnt1       = gnt1_q;
    assign busy       = busy_q;
    assign Tstate     = tstate_q;
    assign Tpriority0 = tp0_q;
    assign TpriorityX = tpx_q;

endmodule

// File: tb/tb_stepdown_prio_sched.sv
module tb_stepdown_prio_sched;

    logic       clk = 1'b0;
    logic       rb;
    logic       req0, req1, rel, tstate_en;
    logic [1:0] prio0_cfg, priox_cfg;
    logic [3:0] hold_min;
    logic       gnt0, gnt1, busy, Tstate;
    logic [1:0] Tpriority0, TpriorityX;

    int unsigned checks = 0;
    int unsigned passes = 0;

    logic [7:0] expq[$];
    string      nameq[$];
    logic [7:0] outv;

`ifdef STEPDOWN_PRIO_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    stepdown_prio_sched #(.SKEW_W(2), .HOLD_W(4)) dut (
        .clk(clk), .rb(rb),
        .CELV(1'b1), .CELG(1'b0), .CELSUB(1'b0),
        .req0(req0), .req1(req1), .rel(rel), .tstate_en(tstate_en),
        .prio0_cfg(prio0_cfg), .priox_cfg(priox_cfg), .hold_min(hold_min),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .Tstate(Tstate),
        .Tpriority0(Tpriority0), .TpriorityX(TpriorityX)
    );

    always #5 clk = ~clk;

    assign outv = {gnt0, gnt1, busy, Tstate, Tpriority0, TpriorityX};

    // Snapshot layout: {gnt0, gnt1, busy, Tstate, Tpriority0, TpriorityX}
    function automatic logic [7:0] s_idle(input logic [1:0] p0, px);
        return {4'b0000, p0, px};
    endfunction
    function automatic logic [7:0] s_arm(input logic [1:0] p0, px);
        return {4'b0011, p0, px};
    endfunction
    function automatic logic [7:0] s_g0(input logic [1:0] p0, px);
        return {4'b1011, p0, px};
    endfunction
    function automatic logic [7:0] s_g1(input logic [1:0] p0, px);
        return {4'b0111, p0, px};
    endfunction
    function automatic logic [7:0] s_drain(input logic [1:0] p0, px);
        return {4'b0010, p0, px};
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got g0g1/busy/tst/tp0/tpx=%b want %b", nm, act, exp);
    endtask

    // One clock of stimulus: drive at negedge, queue what must appear after
    // the following rising edge.
    task automatic cyc(input logic r0, r1, rl, en, input logic [1:0] p0, px,
                       input logic [3:0] hm, input logic [7:0] exp, input string nm);
        @(negedge clk);
        req0 = r0; req1 = r1; rel = rl; tstate_en = en;
        prio0_cfg = p0; priox_cfg = px; hold_min = hm;
        expq.push_back(exp);
        nameq.push_back(nm);
        @(posedge clk);
    endtask

    // Monitor: compares one queued snapshot per rising edge.
    initial begin
        logic [7:0] e;
        string n;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() != 0) begin
                e = expq.pop_front();
                n = nameq.pop_front();
                check(n, outv, e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rb = 1'b0;
        req0 = 1'b0; req1 = 1'b0; rel = 1'b0; tstate_en = 1'b0;
        prio0_cfg = 2'b00; priox_cfg = 2'b00; hold_min = 4'd0;
        #7;
        check("reset_state", outv, 8'h00);
        @(negedge clk);
        rb = 1'b1;

        // Tie-break: two consecutive grants with both requests high
        cyc(1, 1, 0, 1, 2'b01, 2'b11, 0, s_arm(2'b01, 2'b11),   "tie_arm1");
        cyc(1, 1, 0, 1, 2'b01, 2'b11, 0, s_g0(2'b01, 2'b11),    "tie_grant1");
        cyc(1, 1, 1, 1, 2'b01, 2'b11, 0, s_drain(2'b01, 2'b11), "tie_drain1");
        cyc(1, 1, 0, 1, 2'b01, 2'b11, 0, s_idle(2'b01, 2'b11),  "tie_idle_gap");
        cyc(1, 1, 0, 1, 2'b01, 2'b11, 0, s_arm(2'b01, 2'b11),   "tie_arm2");
        cyc(1, 1, 0, 1, 2'b01, 2'b11, 0,
            ROT ? s_g1(2'b01, 2'b11) : s_g0(2'b01, 2'b11),       "tie_grant2");
        cyc(1, 1, 1, 1, 2'b01, 2'b11, 0, s_drain(2'b01, 2'b11), "tie_drain2");
        cyc(0, 0, 0, 1, 2'b01, 2'b11, 0, s_idle(2'b01, 2'b11),  "tie_idle");

        // Basic grant: hold_min=3 with rel held gives 4 GRANT cycles;
        // req0 dropping mid-grant does not end it
        cyc(1, 0, 1, 1, 2'b10, 2'b01, 3, s_arm(2'b10, 2'b01),   "basic_arm");
        cyc(1, 0, 1, 1, 2'b10, 2'b01, 3, s_g0(2'b10, 2'b01),    "basic_g_c1");
        cyc(0, 0, 1, 1, 2'b10, 2'b01, 3, s_g0(2'b10, 2'b01),    "basic_g_c2");
        cyc(0, 0, 1, 1, 2'b10, 2'b01, 3, s_g0(2'b10, 2'b01),    "basic_g_c3");
        cyc(0, 0, 1, 1, 2'b10, 2'b01, 3, s_g0(2'b10, 2'b01),    "basic_g_c4");
        cyc(0, 0, 1, 1, 2'b10, 2'b01, 3, s_drain(2'b10, 2'b01), "basic_drain");
        cyc(0, 0, 0, 1, 2'b10, 2'b01, 3, s_idle(2'b10, 2'b01),  "basic_idle");

        // Withdrawal in ARM: req1 for one cycle only
        cyc(0, 1, 0, 1, 2'b11, 2'b10, 0, s_arm(2'b11, 2'b10),   "wd_arm");
        cyc(0, 0, 0, 1, 2'b11, 2'b10, 0, s_idle(2'b11, 2'b10),  "wd_idle");
        cyc(0, 0, 0, 1, 2'b11, 2'b10, 0, s_idle(2'b11, 2'b10),  "wd_stay_idle");

        // Enable drop in the 2nd GRANT cycle overrides hold_min=15
        cyc(1, 0, 0, 1, 2'b01, 2'b01, 15, s_arm(2'b01, 2'b01),   "en_arm");
        cyc(1, 0, 0, 1, 2'b01, 2'b01, 15, s_g0(2'b01, 2'b01),    "en_grant1");
        cyc(1, 0, 0, 1, 2'b01, 2'b01, 15, s_g0(2'b01, 2'b01),    "en_grant2");
        cyc(1, 0, 0, 0, 2'b01, 2'b01, 15, s_drain(2'b01, 2'b01), "en_drain");
        cyc(1, 0, 0, 0, 2'b01, 2'b01, 15, s_idle(2'b01, 2'b01),  "en_idle");
        cyc(1, 0, 0, 0, 2'b01, 2'b01, 15, s_idle(2'b01, 2'b01),  "en_off_no_arm");

        // Config stability: codes change in GRANT, picked up at next arm
        cyc(1, 0, 0, 1, 2'b10, 2'b00, 2, s_arm(2'b10, 2'b00),   "cfg_arm");
        cyc(1, 0, 0, 1, 2'b10, 2'b00, 2, s_g0(2'b10, 2'b00),    "cfg_g1");
        cyc(1, 0, 0, 1, 2'b01, 2'b11, 2, s_g0(2'b10, 2'b00),    "cfg_g2_stable");
        cyc(1, 0, 0, 1, 2'b01, 2'b11, 2, s_g0(2'b10, 2'b00),    "cfg_g3_stable");
        cyc(1, 0, 1, 1, 2'b01, 2'b11, 2, s_drain(2'b10, 2'b00), "cfg_drain");
        cyc(1, 0, 0, 1, 2'b01, 2'b11, 2, s_idle(2'b10, 2'b00),  "cfg_idle");
        cyc(1, 0, 0, 1, 2'b01, 2'b11, 2, s_arm(2'b01, 2'b11),   "cfg_rearm_new");
        cyc(0, 0, 0, 1, 2'b01, 2'b11, 2, s_idle(2'b01, 2'b11),  "cfg_idle2");

        // Reset mid-GRANT, applied and released between clock edges
        cyc(1, 0, 0, 1, 2'b11, 2'b11, 5, s_arm(2'b11, 2'b11),   "rst_arm");
        cyc(1, 0, 0, 1, 2'b11, 2'b11, 5, s_g0(2'b11, 2'b11),    "rst_grant");
        @(negedge clk);
        #2;
        rb = 1'b0;
        #1;
        check("rst_async_clear", outv, 8'h00);
        @(negedge clk);
        #1;
        check("rst_held", outv, 8'h00);
        rb = 1'b1;
        req0 = 1'b1; req1 = 1'b1; rel = 1'b0; tstate_en = 1'b1;
        prio0_cfg = 2'b01; priox_cfg = 2'b10; hold_min = 4'd0;
        expq.push_back(s_arm(2'b01, 2'b10));
        nameq.push_back("rst_first_edge_arm");
        @(posedge clk);
        cyc(1, 1, 0, 1, 2'b01, 2'b10, 0, s_g0(2'b01, 2'b10),    "rst_tie_req0");
        cyc(1, 1, 1, 1, 2'b01, 2'b10, 0, s_drain(2'b01, 2'b10), "rst_drain");
        cyc(0, 0, 0, 1, 2'b01, 2'b10, 0, s_idle(2'b01, 2'b10),  "rst_idle");

        #5;
        checks++;
        if (expq.size() == 0) passes++;
        else $display("FAIL queue_drain: %0d entries left, want 0", expq.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/stepdown_prio_sched.md
STEPDOWN_PRIO_SCHED -- requirements
Module: stepdown_prio_sched

Interface
REQ-001 The block SHALL have parameter SKEW_W, default 2, which is the width of each timing-skew code.
REQ-002 The block SHALL have parameter HOLD_W, default 4, which is the width of the minimum-hold counter.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset, with ports as follows:
- clk  input  1  single clock; all state changes on the rising edge.
- rb  input  1  asynchronous active-low reset.
- CELV, CELG, CELSUB  input  1 each  supply, ground and substrate pass-through; no logic function.
- req0, req1  input  1 each  level requests from requester 0 and requester X.
- rel  input  1  level release from the current owner.
- tstate_en  input  1  scheduler enable.
- prio0_cfg, priox_cfg  input  SKEW_W each  skew codes for the priority cell.
- hold_min  input  HOLD_W  minimum number of GRANT cycles before a release is honoured.
- gnt0, gnt1  output  1 each  one-hot grant.
- busy  output  1  high in any state other than IDLE.
- Tstate  output  1  drives Tstate on the priority cell.
- Tpriority0, TpriorityX  output  SKEW_W each  registered skew codes for the priority cell.

Function
REQ-004 The FSM SHALL have states IDLE, ARM, GRANT and DRAIN, and all outputs SHALL be registered.
REQ-005 IDLE SHALL go to ARM when tstate_en=1 and (req0|req1)=1; on that edge, Tpriority0 and TpriorityX SHALL load prio0_cfg and priox_cfg.
REQ-006 Tpriority0 and TpriorityX SHALL change only on the IDLE->ARM edge and SHALL stay stable through ARM, GRANT and DRAIN.
REQ-007 ARM SHALL last exactly one cycle.
- If req0 or req1 is still high: go to GRANT and set the winner's grant.
- If both have dropped: go to IDLE with no grant.
REQ-008 Arbitration when both requests are high in ARM:
- Macro absent: req0 wins.
- Macro present: the requester that did not win the last grant wins.
REQ-009 Latency: a request sampled in IDLE at edge N SHALL produce a grant visible after edge N+1.
REQ-010 gnt0 and gnt1 SHALL never be high together, and a grant SHALL be high only in GRANT.
REQ-011 Tstate SHALL be 1 in ARM and GRANT and 0 in IDLE and DRAIN.
REQ-012 Hold counter behaviour:
- Loads hold_min on entry to GRANT.
- Decrements by 1 each GRANT cycle, saturating at 0.
- rel is honoured only in a GRANT cycle where the counter is 0.
- With hold_min=0, rel is honoured in the first GRANT cycle.
REQ-013 When rel is honoured, GRANT SHALL go to DRAIN, with the grant low after that edge.
REQ-014 Dropping the owner's request without rel SHALL NOT end the grant.
REQ-015 DRAIN SHALL last exactly one cycle and then go to IDLE; a request pending in IDLE re-arms on the following edge, so grants are separated by at least 2 cycles.
REQ-016 tstate_en=0 sampled in ARM or GRANT SHALL force DRAIN on that edge, regardless of the hold counter.
REQ-017 busy SHALL equal (state != IDLE).

Reset
REQ-018 While rb=0 the block SHALL asynchronously force the following values:
- state=IDLE.
- gnt0=gnt1=busy=Tstate=0.
- Tpriority0=TpriorityX=0.
- Hold counter=0.
- Last-winner register=requester X, so requester 0 wins the first tie.
REQ-019 Reset asserted mid-GRANT SHALL drop the grant immediately, without waiting for a clock.
REQ-020 The first state change after deassertion SHALL occur on the first rising edge of clk with rb=1.

Configuration
REQ-021 Macro STEPDOWN_PRIO_ROTATE_EN:
- Defined: the tie-break is round-robin per REQ-008 and the last-winner register exists.
- Undefined: fixed priority to req0 and the last-winner register is not built.
- Untied behaviour is identical in both cases.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Basic grant: req0=1 with tstate_en=1, prio0_cfg=2'b10, hold_min=3, rel held from cycle 0. Required: ARM 1 cycle, Tpriority0=2'b10, gnt0 high for exactly 4 cycles, DRAIN, then IDLE.
- Tie-break: req0=req1=1 with two consecutive grants, hold_min=0, rel pulsed. Required: without the macro the grants are gnt0 then gnt0; with the macro they are gnt0 then gnt1.
- Withdrawal in ARM: req1 pulsed for one cycle only. Required: ARM, then IDLE, with gnt1 never asserted and Tpriority codes latched.
- Enable drop: tstate_en cleared in the 2nd GRANT cycle with hold_min=15. Required: DRAIN on the next edge, grant low and Tstate low.
- Reset mid-operation: rb pulsed low between clock edges during GRANT. Required: gnt, busy, Tstate and Tpriority all 0 immediately; on release, a first tie goes to req0.
- Config stability: prio0_cfg changed while in GRANT. Required: Tpriority0 unchanged until the next IDLE->ARM edge.
